// File: rtl/stove_pkg.sv
// ---------------------------------------------------------------------------
// stove_pkg : shared stove controller types and constants
// Rev 1.0   : initial release
// ---------------------------------------------------------------------------
`default_nettype none

package stove_pkg;

  localparam int COOK_UNITS_W = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2,
    ALARM  = 2'd3
  } cook_state_t;

endpackage

`default_nettype wire

// File: rtl/cook_countdown.sv
// ---------------------------------------------------------------------------
// cook_countdown : cook duration counter driven by the 10 s timebase ticks
// Rev 1.0        : initial release
// ---------------------------------------------------------------------------
`default_nettype none

module cook_countdown
  import stove_pkg::*;
#(
  parameter int UNITS_W = COOK_UNITS_W
) (
  input  logic               clk,
  input  logic               async_reset,
  input  logic               start,
  input  logic               pause,
  input  logic               cancel,
  input  logic               ack,
  input  logic               add_unit,
  input  logic [UNITS_W-1:0] duration,
  input  logic               tick,
  output logic               timer_enabled,
  output logic [UNITS_W-1:0] remaining,
  output logic               running,
  output logic               paused,
  output logic               done,
  output logic               alarm
);

  localparam logic [UNITS_W-1:0] c_one = UNITS_W'(1);
  localparam logic [UNITS_W-1:0] c_max = '1;

  cook_state_t        r_state;
  cook_state_t        w_state_nxt;
  logic [UNITS_W-1:0] r_remaining;
  logic [UNITS_W-1:0] w_rem_nxt;
  logic [UNITS_W-1:0] w_rem_inc;
  logic               r_done;
  logic               w_done_nxt;
  logic               w_dur_nz;

  assign w_rem_inc = (r_remaining == c_max) ? r_remaining : r_remaining + c_one;
  assign w_dur_nz  = (duration != '0);

  always_ff @(posedge clk or posedge async_reset) begin
    if (async_reset) begin
      r_state     <= IDLE;
      r_remaining <= '0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_remaining <= w_rem_nxt;
      r_done      <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_rem_nxt   = r_remaining;
    w_done_nxt  = 1'b0;
    if (cancel) begin
      w_state_nxt = IDLE;
      w_rem_nxt   = '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start && w_dur_nz) begin
            w_state_nxt = RUN;
            w_rem_nxt   = duration;
          end
        end
        RUN: begin
          // A simultaneous add_unit cancels the tick's decrement outright.
          if (tick && !add_unit && (r_remaining <= c_one)) begin
            w_state_nxt = ALARM;
            w_rem_nxt   = '0;
            w_done_nxt  = 1'b1;
          end else begin
            if (tick && !add_unit) begin
              w_rem_nxt = r_remaining - c_one;
            end else if (!tick && add_unit) begin
              w_rem_nxt = w_rem_inc;
            end
            if (pause) begin
              w_state_nxt = PAUSED;
            end
          end
        end
        PAUSED: begin
          if (add_unit) begin
            w_rem_nxt = w_rem_inc;
          end
          if (start) begin
            w_state_nxt = RUN;
          end
        end
        ALARM: begin
          if (start && w_dur_nz) begin
            w_state_nxt = RUN;
            w_rem_nxt   = duration;
          end else if (ack) begin
            w_state_nxt = IDLE;
          end
        end
        default: begin
          w_state_nxt = IDLE;
          w_rem_nxt   = '0;
        end
      endcase
    end
  end

  assign timer_enabled = (r_state == RUN);
  assign running       = (r_state == RUN);
  assign paused        = (r_state == PAUSED);
  assign alarm         = (r_state == ALARM);
  assign remaining     = r_remaining;
  assign done          = r_done;

endmodule

`default_nettype wire

// File: tb/tb_cook_countdown.sv
// ---------------------------------------------------------------------------
// tb_cook_countdown : self-checking bench for cook_countdown
// Rev 1.0           : initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tb_cook_countdown;

  logic       clk;
  logic       async_reset;
  logic       start, pause, cancel, ack, add_unit, tick;
  logic [7:0] duration;
  logic       timer_enabled, running, paused, done, alarm;
  logic [7:0] remaining;

  int total;
  int bad;

  // Reference model: mode 0 idle, 1 cooking, 2 on hold, 3 ringing
  int m_mode;
  int m_rem;
  bit m_done;

  cook_countdown #(.UNITS_W(8)) dut (
    .clk(clk), .async_reset(async_reset), .start(start), .pause(pause),
    .cancel(cancel), .ack(ack), .add_unit(add_unit), .duration(duration),
    .tick(tick), .timer_enabled(timer_enabled), .remaining(remaining),
    .running(running), .paused(paused), .done(done), .alarm(alarm)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [12:0] exp_vec();
    return {m_mode == 1, m_mode == 2, m_mode == 3, m_mode == 1, m_done, 8'(m_rem)};
  endfunction

  function automatic logic [12:0] dut_vec();
    return {running, paused, alarm, timer_enabled, done, remaining};
  endfunction

  function automatic void model_reset();
    m_mode = 0; m_rem = 0; m_done = 0;
  endfunction

  function automatic void model_step(bit st, bit pa, bit ca, bit ak, bit ad, bit tk, int du);
    m_done = 0;
    if (ca) begin
      m_mode = 0; m_rem = 0;
    end else if (m_mode == 0) begin
      if (st && du != 0) begin m_mode = 1; m_rem = du; end
    end else if (m_mode == 1) begin
      if (tk && !ad && m_rem == 1) begin
        m_mode = 3; m_rem = 0; m_done = 1;
      end else begin
        if (tk && !ad) m_rem = m_rem - 1;
        else if (!tk && ad && m_rem < 255) m_rem = m_rem + 1;
        if (pa) m_mode = 2;
      end
    end else if (m_mode == 2) begin
      if (ad && m_rem < 255) m_rem = m_rem + 1;
      if (st) m_mode = 1;
    end else begin
      if (st && du != 0) begin m_mode = 1; m_rem = du; end
      else if (ak) m_mode = 0;
    end
  endfunction

  // One clock: apply pulses, advance the model, then sample 1 time unit after the edge.
  task automatic drive(input bit st, input bit pa, input bit ca, input bit ak,
                       input bit ad, input bit tk, input int du);
    start = st; pause = pa; cancel = ca; ack = ak; add_unit = ad; tick = tk;
    duration = 8'(du);
    model_step(st, pa, ca, ak, ad, tk, du);
    @(posedge clk);
    #1;
    start = 0; pause = 0; cancel = 0; ack = 0; add_unit = 0; tick = 0;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_reset();
    async_reset = 1;
    model_reset();
    #1;
    total++;
    if (dut_vec() !== 13'd0) begin
      bad++; $display("FAIL reset_during got=%h exp=%h", dut_vec(), 13'd0);
    end
    @(posedge clk); #3;
    async_reset = 0;
    @(posedge clk); #1;
    total++;
    if (dut_vec() !== exp_vec()) begin
      bad++; $display("FAIL reset_after got=%h exp=%h", dut_vec(), exp_vec());
    end
  endtask

  task automatic test_basic();
    int ticks_seen;
    ticks_seen = 0;
    drive(1, 0, 0, 0, 0, 0, 3);
    total++;
    if (remaining !== 8'd3 || running !== 1'b1 || timer_enabled !== 1'b1) begin
      bad++; $display("FAIL basic_load got rem=%0d run=%b te=%b exp rem=3 run=1 te=1",
                      remaining, running, timer_enabled);
    end
    for (int c = 1; c <= 30; c++) begin
      drive(0, 0, 0, 0, 0, (c % 10) == 0, 0);
      total++;
      if (dut_vec() !== exp_vec()) begin
        bad++; $display("FAIL basic_cycle%0d got=%h exp=%h", c, dut_vec(), exp_vec());
      end
    end
    total++;
    if (done !== 1'b1 || alarm !== 1'b1 || remaining !== 8'd0) begin
      bad++; $display("FAIL basic_expiry got done=%b alarm=%b rem=%0d exp done=1 alarm=1 rem=0",
                      done, alarm, remaining);
    end
    idle_cycles(3);
    total++;
    if (done !== 1'b0 || alarm !== 1'b1) begin
      bad++; $display("FAIL basic_alarm_hold got done=%b alarm=%b exp done=0 alarm=1", done, alarm);
    end
    drive(0, 0, 0, 1, 0, 0, 0);
    total++;
    if (dut_vec() !== 13'd0) begin
      bad++; $display("FAIL basic_ack got=%h exp=%h", dut_vec(), 13'd0);
    end
  endtask

  task automatic test_zero_start();
    drive(1, 0, 0, 0, 0, 0, 0);
    total++;
    if (running !== 1'b0 || timer_enabled !== 1'b0 || dut_vec() !== exp_vec()) begin
      bad++; $display("FAIL zero_start got=%h exp=%h", dut_vec(), exp_vec());
    end
  endtask

  task automatic test_pause();
    drive(1, 0, 0, 0, 0, 0, 5);
    drive(0, 0, 0, 0, 0, 1, 0);
    drive(0, 0, 0, 0, 0, 1, 0);
    drive(0, 1, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 1, 0);
    total++;
    if (remaining !== 8'd3 || timer_enabled !== 1'b0 || paused !== 1'b1) begin
      bad++; $display("FAIL pause_hold got rem=%0d te=%b paused=%b exp rem=3 te=0 paused=1",
                      remaining, timer_enabled, paused);
    end
    drive(1, 0, 0, 0, 0, 0, 9);
    total++;
    if (remaining !== 8'd3 || running !== 1'b1 || dut_vec() !== exp_vec()) begin
      bad++; $display("FAIL pause_resume got=%h exp=%h", dut_vec(), exp_vec());
    end
    drive(0, 0, 1, 0, 0, 0, 0);
  endtask

  task automatic test_add_tick();
    drive(1, 0, 0, 0, 0, 0, 2);
    drive(0, 0, 0, 0, 0, 1, 0);
    drive(0, 0, 0, 0, 1, 1, 0);
    total++;
    if (remaining !== 8'd1 || done !== 1'b0 || running !== 1'b1) begin
      bad++; $display("FAIL add_tick got rem=%0d done=%b run=%b exp rem=1 done=0 run=1",
                      remaining, done, running);
    end
    drive(0, 0, 0, 0, 0, 1, 0);
    total++;
    if (done !== 1'b1 || alarm !== 1'b1 || dut_vec() !== exp_vec()) begin
      bad++; $display("FAIL add_tick_expire got=%h exp=%h", dut_vec(), exp_vec());
    end
    drive(0, 0, 0, 1, 0, 0, 0);
  endtask

  task automatic test_saturate_cancel();
    drive(1, 0, 0, 0, 0, 0, 255);
    drive(0, 0, 0, 0, 1, 0, 0);
    total++;
    if (remaining !== 8'd255) begin
      bad++; $display("FAIL saturate got=%0d exp=255", remaining);
    end
    drive(0, 0, 1, 0, 0, 1, 0);
    total++;
    if (dut_vec() !== 13'd0) begin
      bad++; $display("FAIL cancel_tick got=%h exp=%h", dut_vec(), 13'd0);
    end
  endtask

  task automatic test_async_reset();
    drive(1, 0, 0, 0, 0, 0, 4);
    #3;
    async_reset = 1;
    model_reset();
    #1;
    total++;
    if (dut_vec() !== 13'd0) begin
      bad++; $display("FAIL async_reset got=%h exp=%h", dut_vec(), 13'd0);
    end
    @(posedge clk); #2;
    async_reset = 0;
    @(posedge clk); #1;
    drive(0, 0, 0, 0, 0, 1, 0);
    total++;
    if (dut_vec() !== 13'd0) begin
      bad++; $display("FAIL reset_tick got=%h exp=%h", dut_vec(), 13'd0);
    end
  endtask

  task automatic test_random();
    bit st, pa, ca, ak, ad, tk;
    int du;
    for (int i = 0; i < 400; i++) begin
      st = ($urandom_range(0, 7) == 0);
      pa = ($urandom_range(0, 9) == 0);
      ca = ($urandom_range(0, 39) == 0);
      ak = ($urandom_range(0, 5) == 0);
      ad = ($urandom_range(0, 7) == 0);
      tk = ($urandom_range(0, 2) == 0);
      du = ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(1, 6));
      if ($urandom_range(0, 49) == 0) du = 254;
      drive(st, pa, ca, ak, ad, tk, du);
      total++;
      if (dut_vec() !== exp_vec()) begin
        bad++; $display("FAIL random_step%0d got=%h exp=%h", i, dut_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    total = 0; bad = 0;
    start = 0; pause = 0; cancel = 0; ack = 0; add_unit = 0; tick = 0;
    duration = 8'd0;
    test_reset();
    test_basic();
    test_zero_start();
    test_pause();
    test_add_tick();
    test_saturate_cancel();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
